node_link: RTL and testbench

Point-to-point nibble channel between neighbouring `node_arctic` instances. It accepts 4-bit words from an upstream node's `out` with a valid/ready handshake and buffers them in a small FIFO. It presents them to a downstream node input (A/B/C/D) with the same handshake. When the FIFO is empty, the output holds the last delivered word, so the consuming node always sees a stable operand. One instance is placed on every inter-node edge of the array, directly downstream of a node's output.

---
 rtl/node_pkg.sv | 9 +
 rtl/node_link.sv | 79 +++++++
 tb/tb_node_link.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/node_pkg.sv
// Shared definitions for the node array: nibble width and the nibble type used
// by node ports and the inter-node links.
package node_pkg;

    localparam int NIBBLE_W = 4;

    typedef logic [NIBBLE_W-1:0] nibble_t;

endpackage

// File: rtl/node_link.sv
// Point-to-point nibble channel between neighbouring nodes: a small valid/ready
// FIFO whose output holds the last delivered word while empty.
module node_link
    import node_pkg::*;
#(
    parameter int WIDTH = NIBBLE_W,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] occupancy;
    logic [WIDTH-1:0] last;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // One subtraction feeds level, full and empty; the wrap bit makes
    // occupancy == DEPTH distinguishable from occupancy == 0.
    assign occupancy = wr_ptr - rd_ptr;
    assign empty     = (occupancy == '0);
    assign full      = (occupancy == PTR_W'(DEPTH));

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && !full;
    assign pop       = !empty && out_ready;

    assign out_data = empty ? last : mem[rd_idx];
    assign level    = occupancy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            last   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                last   <= mem[rd_idx];
            end
        end
    end

    // Storage is deliberately not reset; entries are only read once written.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_idx] <= in_data;
        end
    end

endmodule

// File: tb/tb_node_link.sv
// Self-checking bench for node_link: directed boundary scenarios plus random
// traffic compared every cycle against a queue-based model of the channel.
module tb_node_link;
    import node_pkg::*;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    nibble_t       in_data;
    logic          in_valid;
    logic          in_ready;
    nibble_t       out_data;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] level;

    int n_vectors     = 0;
    int n_miscompares = 0;

    nibble_t model_q[$];
    nibble_t model_last = '0;
    bit      can_push;
    bit      can_pop;

    node_link #(.WIDTH(NIBBLE_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [7:0] actual,
                                input logic [7:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle's inputs, then return just after the following edge.
    task automatic apply_stimulus(input logic v, input nibble_t d, input logic r,
                                  input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #1;
    endtask

    // Channel model: a FIFO of at most DEPTH words plus the last word handed out.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q.delete();
            model_last = '0;
        end else begin
            can_push = (model_q.size() < DEPTH);
            can_pop  = (model_q.size() > 0);
            if (flush) begin
                model_q.delete();
            end else begin
                if (can_pop && out_ready) model_last = model_q.pop_front();
                if (can_push && in_valid) model_q.push_back(in_data);
            end
        end
    end

    always @(negedge clk) begin
        check_output("cmp in_ready", {7'd0, in_ready}, {7'd0, model_q.size() < DEPTH});
        check_output("cmp out_valid", {7'd0, out_valid}, {7'd0, model_q.size() > 0});
        check_output("cmp level", 8'(level), 8'(model_q.size()));
        check_output("cmp out_data", {4'd0, out_data},
                     {4'd0, (model_q.size() > 0) ? model_q[0] : model_last});
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset in_ready", {7'd0, in_ready}, 8'd1);
        check_output("reset out_valid", {7'd0, out_valid}, 8'd0);
        check_output("reset out_data", {4'd0, out_data}, 8'd0);
        check_output("reset level", 8'(level), 8'd0);
        rst_n = 1'b1;

        // Fill to full, then drain in order.
        for (int i = 1; i <= 4; i++) apply_stimulus(1'b1, nibble_t'(i), 1'b0, 1'b0);
        check_output("fill level", 8'(level), 8'd4);
        check_output("fill in_ready", {7'd0, in_ready}, 8'd0);
        check_output("fill out_data", {4'd0, out_data}, 8'd1);
        for (int i = 1; i <= 4; i++) begin
            check_output("drain out_data", {4'd0, out_data}, 8'(i));
            apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        end
        check_output("drained out_valid", {7'd0, out_valid}, 8'd0);
        check_output("drained holds last", {4'd0, out_data}, 8'd4);

        // Full boundary: pop without bypass, then the retried word enters.
        for (int i = 5; i <= 8; i++) apply_stimulus(1'b1, nibble_t'(i), 1'b0, 1'b0);
        apply_stimulus(1'b1, 4'd9, 1'b1, 1'b0);
        check_output("full pop level", 8'(level), 8'd3);
        check_output("full pop head", {4'd0, out_data}, 8'd6);
        apply_stimulus(1'b1, 4'd9, 1'b0, 1'b0);
        check_output("full retry level", 8'(level), 8'd4);
        for (int i = 6; i <= 9; i++) begin
            check_output("full drain", {4'd0, out_data}, 8'(i));
            apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        end

        // Empty boundary: no fall-through of a word pushed while empty.
        apply_stimulus(1'b1, 4'd7, 1'b0, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        check_output("empty out_valid", {7'd0, out_valid}, 8'd0);
        check_output("empty last", {4'd0, out_data}, 8'd7);
        apply_stimulus(1'b1, 4'hA, 1'b1, 1'b0);
        check_output("empty push valid", {7'd0, out_valid}, 8'd1);
        check_output("empty push data", {4'd0, out_data}, 8'h0A);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);

        // Flush with a concurrent push: contents dropped, last kept.
        apply_stimulus(1'b1, 4'd5, 1'b0, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        apply_stimulus(1'b1, 4'd1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 4'd2, 1'b0, 1'b0);
        check_output("pre-flush level", 8'(level), 8'd2);
        apply_stimulus(1'b1, 4'hC, 1'b0, 1'b1);
        check_output("flush level", 8'(level), 8'd0);
        check_output("flush out_data", {4'd0, out_data}, 8'd5);
        check_output("flush out_valid", {7'd0, out_valid}, 8'd0);

        // Streaming across pointer wrap: each word appears one cycle after push.
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b1, nibble_t'(i), 1'b1, 1'b0);
            check_output("stream data", {4'd0, out_data}, 8'(i));
            check_output("stream level", 8'(level), 8'd1);
        end
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        check_output("stream end level", 8'(level), 8'd0);

        // Asynchronous reset mid-stream with three words buffered.
        for (int i = 1; i <= 3; i++) apply_stimulus(1'b1, nibble_t'(i), 1'b0, 1'b0);
        check_output("pre-reset level", 8'(level), 8'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async rst in_ready", {7'd0, in_ready}, 8'd1);
        check_output("async rst out_valid", {7'd0, out_valid}, 8'd0);
        check_output("async rst out_data", {4'd0, out_data}, 8'd0);
        check_output("async rst level", 8'(level), 8'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Random traffic, checked by the model on every cycle.
        for (int n = 0; n < 3000; n++) begin
            apply_stimulus(1'($urandom_range(0, 3) != 0), nibble_t'($urandom),
                           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
